// File: rtl/ibex_mem_arbiter.sv
// rtl/ibex_mem_arbiter.sv - shares one req/gnt/rvalid memory port between Ibex fetch and load/store
//
// Ports:
//   clk_i, rst_i                     clock (rising edge), asynchronous active-high reset
//   instr_req_i/gnt_o/addr_i         fetch request channel
//   instr_rvalid_o/rdata_o/err_o     fetch response channel
//   data_req_i/gnt_o/we_i/be_i/
//     addr_i/wdata_i                 load/store request channel
//   data_rvalid_o/rdata_o/err_o      load/store response channel
//   mem_req_o/gnt_i/we_o/be_o/
//     addr_o/wdata_o                 shared memory request channel
//   mem_rvalid_i/rdata_i/err_i       shared memory response channel
//   spurious_rsp_o                   registered pulse: a response arrived with nothing in flight
//   outstanding_o                    registered count of in-flight transactions

module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   instr_req_i,
    output logic                   instr_gnt_o,
    input  logic [AddrWidth-1:0]   instr_addr_i,
    output logic                   instr_rvalid_o,
    output logic [DataWidth-1:0]   instr_rdata_o,
    output logic                   instr_err_o,

    input  logic                   data_req_i,
    output logic                   data_gnt_o,
    input  logic                   data_we_i,
    input  logic [DataWidth/8-1:0] data_be_i,
    input  logic [AddrWidth-1:0]   data_addr_i,
    input  logic [DataWidth-1:0]   data_wdata_i,
    output logic                   data_rvalid_o,
    output logic [DataWidth-1:0]   data_rdata_o,
    output logic                   data_err_o,

    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic                   mem_we_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    input  logic                   mem_err_i,

    output logic                   spurious_rsp_o,
    output logic [2:0]             outstanding_o
);

    localparam int unsigned BeWidth = DataWidth / 8;

    // Storage is sized for the largest legal depth (4); the pointers wrap at
    // MaxOutstanding so smaller configurations simply leave upper slots idle.
    localparam logic [2:0] MaxCount = 3'(MaxOutstanding);
    localparam logic [1:0] LastIdx  = 2'(MaxOutstanding - 1);

    localparam logic OwnerInstr = 1'b0;
    localparam logic OwnerData  = 1'b1;

    // In-order record of who issued each in-flight transaction.
    logic [3:0] id_fifo_q;
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;

    // Selection state: last_grant_q drives round-robin, lock_* pins a stalled
    // requester so its attributes stay on the bus until it is granted.
    logic       last_grant_q;
    logic       lock_valid_q;
    logic       lock_owner_q;

    logic       spurious_q;

    logic       full;
    logic       empty;
    logic       sel_valid;
    logic       sel_owner;
    logic       sel_req;
    logic       push;
    logic       pop;
    logic       head_owner;

    function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
        return (ptr == LastIdx) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Full is taken from the registered count only: a response popping in
    // the same cycle does not free a slot until the next cycle.
    assign full  = (count_q == MaxCount);
    assign empty = (count_q == 3'd0);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        sel_valid = 1'b0;
        sel_owner = OwnerInstr;
        if (!full) begin
            if (lock_valid_q) begin
                sel_valid = 1'b1;
                sel_owner = lock_owner_q;
            end else if (instr_req_i && data_req_i) begin
                sel_valid = 1'b1;
                sel_owner = ~last_grant_q;
            end else if (instr_req_i) begin
                sel_valid = 1'b1;
                sel_owner = OwnerInstr;
            end else if (data_req_i) begin
                sel_valid = 1'b1;
                sel_owner = OwnerData;
            end
        end
    end

    // A locked owner that has withdrawn its request leaves sel_valid set but
    // sel_req low, so nothing is driven and the lock drops next cycle.
    assign sel_req = sel_valid && ((sel_owner == OwnerData) ? data_req_i : instr_req_i);

    // ------------------------------------------------------------------
    // Request drive
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_o   = sel_req;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (sel_req) begin
            if (sel_owner == OwnerData) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                // Fetches are always full-word reads.
                mem_be_o    = {BeWidth{1'b1}};
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    assign instr_gnt_o = mem_gnt_i && sel_req && (sel_owner == OwnerInstr);
    assign data_gnt_o  = mem_gnt_i && sel_req && (sel_owner == OwnerData);

    assign push = sel_req && mem_gnt_i;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    assign pop        = mem_rvalid_i && !empty;
    assign head_owner = id_fifo_q[rd_ptr_q];

    always_comb begin
        instr_rvalid_o = pop && (head_owner == OwnerInstr);
        data_rvalid_o  = pop && (head_owner == OwnerData);
        // Payload is masked on the port that is not receiving a response.
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
        instr_err_o    = instr_rvalid_o && mem_err_i;
        data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
        data_err_o     = data_rvalid_o && mem_err_i;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_fifo_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            if (push) begin
                id_fifo_q[wr_ptr_q] <= sel_owner;
                wr_ptr_q            <= ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= OwnerData;
            lock_valid_q <= 1'b0;
            lock_owner_q <= OwnerInstr;
        end else begin
            if (push) begin
                last_grant_q <= sel_owner;
                lock_valid_q <= 1'b0;
            end else if (sel_req) begin
                // Stalled: hold this owner until the memory grants it.
                lock_valid_q <= 1'b1;
                lock_owner_q <= sel_owner;
            end else begin
                lock_valid_q <= 1'b0;
            end
        end
    end

    // A response with nothing in flight is swallowed and reported one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= mem_rvalid_i && empty;
        end
    end

    assign spurious_rsp_o = spurious_q;
    assign outstanding_o  = count_q;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb/tb_ibex_mem_arbiter.sv - self-checking bench for ibex_mem_arbiter

module tb_ibex_mem_arbiter;

    localparam int MO = 2;

    logic        clk_i;
    logic        rst_i;
    logic        instr_req_i, instr_gnt_o;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;
    logic        spurious_rsp_o;
    logic [2:0]  outstanding_o;

    ibex_mem_arbiter #(.MaxOutstanding(MO), .AddrWidth(32), .DataWidth(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .spurious_rsp_o(spurious_rsp_o), .outstanding_o(outstanding_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        ir, dr, dw, g, rv, er;
        logic [31:0] ia, da, dd, rd;
        logic [3:0]  db;
    } in_t;

    typedef struct {
        logic        req, we, ig, dg, irv, ie, drv, de, sp;
        logic [31:0] addr, wd, ird, drd;
        logic [3:0]  be;
        logic [2:0]  outst;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    function automatic in_t mk_in(logic ir, logic [31:0] ia, logic dr, logic dw, logic [3:0] db,
                                  logic [31:0] da, logic [31:0] dd, logic g, logic rv,
                                  logic [31:0] rd, logic er);
        in_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.db = db; v.da = da; v.dd = dd;
        v.g = g; v.rv = rv; v.rd = rd; v.er = er;
        return v;
    endfunction

    function automatic exp_t mk_exp(logic req, logic [31:0] addr, logic we, logic [3:0] be,
                                    logic [31:0] wd, logic ig, logic dg, logic irv,
                                    logic [31:0] ird, logic ie, logic drv, logic [31:0] drd,
                                    logic de, logic sp, logic [2:0] outst);
        exp_t e;
        e.req = req; e.addr = addr; e.we = we; e.be = be; e.wd = wd; e.ig = ig; e.dg = dg;
        e.irv = irv; e.ird = ird; e.ie = ie; e.drv = drv; e.drd = drd; e.de = de;
        e.sp = sp; e.outst = outst;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input in_t v);
        instr_req_i  = v.ir; instr_addr_i = v.ia;
        data_req_i   = v.dr; data_we_i = v.dw; data_be_i = v.db;
        data_addr_i  = v.da; data_wdata_i = v.dd;
        mem_gnt_i    = v.g;  mem_rvalid_i = v.rv; mem_rdata_i = v.rd; mem_err_i = v.er;
    endtask

    task automatic check_out(input exp_t e, input string tag);
        chk({tag, "/mem_req"},     {31'd0, mem_req_o},      {31'd0, e.req});
        chk({tag, "/mem_addr"},    mem_addr_o,              e.addr);
        chk({tag, "/mem_we"},      {31'd0, mem_we_o},       {31'd0, e.we});
        chk({tag, "/mem_be"},      {28'd0, mem_be_o},       {28'd0, e.be});
        chk({tag, "/mem_wdata"},   mem_wdata_o,             e.wd);
        chk({tag, "/instr_gnt"},   {31'd0, instr_gnt_o},    {31'd0, e.ig});
        chk({tag, "/data_gnt"},    {31'd0, data_gnt_o},     {31'd0, e.dg});
        chk({tag, "/instr_rvalid"},{31'd0, instr_rvalid_o}, {31'd0, e.irv});
        chk({tag, "/instr_rdata"}, instr_rdata_o,           e.ird);
        chk({tag, "/instr_err"},   {31'd0, instr_err_o},    {31'd0, e.ie});
        chk({tag, "/data_rvalid"}, {31'd0, data_rvalid_o},  {31'd0, e.drv});
        chk({tag, "/data_rdata"},  data_rdata_o,            e.drd);
        chk({tag, "/data_err"},    {31'd0, data_err_o},     {31'd0, e.de});
        chk({tag, "/spurious"},    {31'd0, spurious_rsp_o}, {31'd0, e.sp});
        chk({tag, "/outstanding"}, {29'd0, outstanding_o},  {29'd0, e.outst});
    endtask

    // Entered 1 time unit after a rising edge; leaves at the same phase of the next cycle.
    task automatic step(input in_t v, input exp_t e, input string tag);
        apply(v);
        #3;
        check_out(e, tag);
        @(posedge clk_i);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of issuer tags plus the pending-stall owner.
    // ------------------------------------------------------------------
    bit mq[$];
    bit m_last_data;
    bit m_lock;
    int m_lock_owner;
    bit m_spur;

    task automatic model_reset();
        mq.delete();
        m_last_data  = 1'b1;
        m_lock       = 1'b0;
        m_lock_owner = 0;
        m_spur       = 1'b0;
    endtask

    // -1 = nobody, 0 = fetch, 1 = load/store
    function automatic int m_owner(input in_t v);
        if (mq.size() >= MO) return -1;
        if (m_lock)          return m_lock_owner;
        if (v.ir && v.dr)    return m_last_data ? 0 : 1;
        if (v.ir)            return 0;
        if (v.dr)            return 1;
        return -1;
    endfunction

    function automatic bit m_active(input in_t v, input int o);
        return (o == 0 && v.ir) || (o == 1 && v.dr);
    endfunction

    function automatic exp_t model_eval(input in_t v);
        exp_t e;
        int   o;
        e = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o = m_owner(v);
        if (m_active(v, o)) begin
            e.req = 1'b1;
            if (o == 0) begin
                e.addr = v.ia; e.be = 4'hf; e.ig = v.g;
            end else begin
                e.addr = v.da; e.we = v.dw; e.be = v.db; e.wd = v.dd; e.dg = v.g;
            end
        end
        if (v.rv && mq.size() > 0) begin
            if (mq[0] == 1'b0) begin
                e.irv = 1'b1; e.ird = v.rd; e.ie = v.er;
            end else begin
                e.drv = 1'b1; e.drd = v.rd; e.de = v.er;
            end
        end
        e.sp    = m_spur;
        e.outst = 3'(mq.size());
        return e;
    endfunction

    task automatic model_step(input in_t v);
        int o;
        bit had;
        o   = m_owner(v);
        had = mq.size() > 0;
        m_spur = v.rv && !had;
        if (m_active(v, o) && v.g) begin
            mq.push_back(o == 1);
            m_last_data = (o == 1);
            m_lock = 1'b0;
        end else if (m_active(v, o)) begin
            m_lock = 1'b1;
            m_lock_owner = o;
        end else begin
            m_lock = 1'b0;
        end
        if (v.rv && had) void'(mq.pop_front());
    endtask

    localparam logic [31:0] IA = 32'h0000_0100;
    localparam logic [31:0] DA = 32'h0000_2000;
    localparam logic [31:0] DD = 32'hcafe_0001;

    vec_t tbl[$];

    initial begin
        in_t  idle;
        exp_t z;
        in_t  v;
        exp_t e;

        idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        z    = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Round-robin from reset, with responses returning in grant order.
        tbl.push_back('{mk_in(1, IA, 1, 1, 4'h3, DA, DD, 1, 0, 0, 0),
                        mk_exp(1, IA, 0, 4'hf, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mk_in(1, IA, 1, 1, 4'h3, DA, DD, 1, 1, 32'h11, 0),
                        mk_exp(1, DA, 1, 4'h3, DD, 0, 1, 1, 32'h11, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mk_in(1, IA, 1, 1, 4'h3, DA, DD, 1, 1, 32'h22, 0),
                        mk_exp(1, IA, 0, 4'hf, 0, 1, 0, 0, 0, 0, 1, 32'h22, 0, 0, 1)});
        tbl.push_back('{mk_in(1, IA, 1, 1, 4'h3, DA, DD, 1, 1, 32'h33, 0),
                        mk_exp(1, DA, 1, 4'h3, DD, 0, 1, 1, 32'h33, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mk_in(0, IA, 0, 1, 4'h3, DA, DD, 1, 1, 32'h44, 1),
                        mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44, 1, 0, 1)});
        tbl.push_back('{idle, z});
        // Single fetch.
        tbl.push_back('{mk_in(1, 32'h80, 0, 0, 0, 0, 0, 1, 0, 0, 0),
                        mk_exp(1, 32'h80, 0, 4'hf, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13, 0),
                        mk_exp(0, 0, 0, 0, 0, 0, 0, 1, 32'h13, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{idle, z});
        // Lock: fetch stalls three cycles, load raised meanwhile.
        tbl.push_back('{mk_in(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                        mk_exp(1, 32'h80, 0, 4'hf, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mk_in(1, 32'h80, 1, 0, 4'hf, DA, 0, 0, 0, 0, 0),
                        mk_exp(1, 32'h80, 0, 4'hf, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mk_in(1, 32'h80, 1, 0, 4'hf, DA, 0, 0, 0, 0, 0),
                        mk_exp(1, 32'h80, 0, 4'hf, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mk_in(1, 32'h80, 1, 0, 4'hf, DA, 0, 1, 0, 0, 0),
                        mk_exp(1, 32'h80, 0, 4'hf, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mk_in(0, 32'h80, 1, 0, 4'hf, DA, 0, 1, 0, 0, 0),
                        mk_exp(1, DA, 0, 4'hf, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5, 0),
                        mk_exp(0, 0, 0, 0, 0, 0, 0, 1, 32'h5, 0, 0, 0, 0, 0, 2)});
        tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h6, 0),
                        mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h6, 0, 0, 1)});
        // Spurious error response, then an err without rvalid.
        tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hffff, 1), z});
        tbl.push_back('{idle, mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
        tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 1), z});

        rst_i = 1'b1;
        apply(idle);
        @(posedge clk_i);
        #1;
        check_out(z, "reset");
        rst_i = 1'b0;

        foreach (tbl[k]) begin
            step(tbl[k].i, tbl[k].e, $sformatf("tbl%0d", k));
        end

        // Full: two in flight blocks further requests until a response frees a slot.
        step(mk_in(1, 32'h80, 0, 0, 0, 0, 0, 1, 0, 0, 0),
             mk_exp(1, 32'h80, 0, 4'hf, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "full_a");
        step(mk_in(0, 32'h80, 1, 0, 4'hf, DA, 0, 1, 0, 0, 0),
             mk_exp(1, DA, 0, 4'hf, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), "full_b");
        step(mk_in(0, 32'h80, 1, 0, 4'hf, DA, 0, 1, 0, 0, 0),
             mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), "full_c");
        step(mk_in(0, 32'h80, 1, 0, 4'hf, DA, 0, 1, 1, 32'h77, 0),
             mk_exp(0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 0, 0, 0, 0, 0, 2), "full_d");
        step(mk_in(0, 32'h80, 1, 0, 4'hf, DA, 0, 1, 0, 0, 0),
             mk_exp(1, DA, 0, 4'hf, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), "full_e");
        step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h88, 0),
             mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h88, 0, 0, 2), "full_f");
        step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0),
             mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0, 0, 1), "full_g");
        step(idle, z, "full_h");

        // Reset while a load is in flight; its late response is spurious.
        step(mk_in(0, 0, 1, 0, 4'hf, 32'h3000, 0, 1, 0, 0, 0),
             mk_exp(1, 32'h3000, 0, 4'hf, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rst_a");
        apply(idle);
        rst_i = 1'b1;
        #2;
        check_out(z, "rst_b");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0), z, "rst_c");
        step(idle, mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "rst_d");
        step(idle, z, "rst_e");

        // Randomized traffic against the reference model, including
        // withdrawn requests and responses with nothing pending.
        apply(idle);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        for (int n = 0; n < 800; n++) begin
            v.ir = ($urandom_range(0, 99) < 55);
            v.dr = ($urandom_range(0, 99) < 55);
            v.ia = {$urandom_range(0, 255), 2'b00};
            v.da = $urandom;
            v.dd = $urandom;
            v.dw = 1'($urandom_range(0, 1));
            v.db = 4'($urandom_range(0, 15));
            v.g  = ($urandom_range(0, 99) < 65);
            v.rv = ($urandom_range(0, 99) < 40);
            v.rd = $urandom;
            v.er = 1'($urandom_range(0, 1));
            e = model_eval(v);
            apply(v);
            #3;
            check_out(e, $sformatf("rand%0d", n));
            model_step(v);
            @(posedge clk_i);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ibex_mem_arbiter.md
# ibex_mem_arbiter

Shares one memory port between the Ibex instruction-fetch and load/store interfaces, both using the req/gnt/rvalid/err protocol. Sits between `ibex_top` and the single-ported memory or bus in the test and FPGA harnesses. It tracks outstanding transactions in order and routes every response to the requester that issued it. Responses with no matching outstanding request are dropped and flagged, never forwarded. This includes `rvalid`/`err` pulses arriving while nothing is pending.

## Interface
Parameters:
- `MaxOutstanding`, 2, in-flight transaction limit, legal 1..4.
- `AddrWidth`, 32, address width.
- `DataWidth`, 32, data width; byte enables are `DataWidth/8`.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `instr_req_i` in 1, `instr_gnt_o` out 1, `instr_addr_i` in AddrWidth: fetch request.
- `instr_rvalid_o` out 1, `instr_rdata_o` out DataWidth, `instr_err_o` out 1: fetch response.
- `data_req_i` in 1, `data_gnt_o` out 1, `data_we_i` in 1, `data_be_i` in DataWidth/8, `data_addr_i` in AddrWidth, `data_wdata_i` in DataWidth: load/store request.
- `data_rvalid_o` out 1, `data_rdata_o` out DataWidth, `data_err_o` out 1: load/store response.
- `mem_req_o` out 1, `mem_gnt_i` in 1, `mem_we_o` out 1, `mem_be_o` out DataWidth/8, `mem_addr_o` out AddrWidth, `mem_wdata_o` out DataWidth: memory request.
- `mem_rvalid_i` in 1, `mem_rdata_i` in DataWidth, `mem_err_i` in 1: memory response.
- `spurious_rsp_o` out 1: one-cycle pulse when a response is dropped.
- `outstanding_o` out 3: current in-flight count.

## Operation
- **ID FIFO:** depth `MaxOutstanding`, 1-bit entries (0 = instr, 1 = data), plus an occupancy counter.
- **Full:** count == `MaxOutstanding`. While full, `mem_req_o` = 0 and both grants are 0.
- **Selection state:** `last_grant` register (reset = data, so instr wins the first tie) and `lock` register holding `{valid, owner}`.
- **Arbitration (not full):**
  - If `lock.valid`, the owner is selected.
  - Otherwise a single requester is selected directly.
  - If both request, the requester ≠ `last_grant` is selected (round-robin).
- **Request drive:**
  - `mem_req_o` = selected requester's req.
  - Address, we, be and wdata are muxed from the selected requester.
  - An instr selection drives we = 0 and be = all-ones.
  - No requester: mem outputs are driven to 0.
- **Grant:** `<sel>_gnt_o` = `mem_gnt_i` & `mem_req_o`. The unselected grant is 0.
- **Handshake completes** (`mem_req_o` & `mem_gnt_i`):
  - The owner ID is pushed into the FIFO.
  - `last_grant` ← owner; `lock` is cleared.
- **Stall** (`mem_req_o` & !`mem_gnt_i`): `lock` ← {1, owner}. The owner stays selected until granted, even if the other requester raises req. This meets Ibex's rule that request attributes are held stable until grant.
- **Withdrawn request:** if the locked owner drops req (protocol violation), `lock` is cleared the next cycle and no push happens.
- **Response** (`mem_rvalid_i` = 1):
  - FIFO non-empty: pop the head and assert `<head>_rvalid_o`. `rdata_o` = `mem_rdata_i`; `err_o` = `mem_err_i`.
  - FIFO empty: drop the response. Both rvalid outputs stay 0 and `spurious_rsp_o` pulses the next cycle.
- **Ignored inputs:** `mem_err_i` without `mem_rvalid_i` is ignored. `mem_rdata_i` and `mem_err_i` are not forwarded to the non-head port.
- **Response masking:** `instr_rdata_o`/`data_rdata_o` are 0 and `err_o` is 0 whenever that port's rvalid is 0.
- **Simultaneous push and pop:** the count is unchanged and both operations happen. The full check uses the registered count, so there is no bypass.

## Timing
- **Request path:** purely combinational from req/gnt inputs to mem outputs and grants; zero added latency.
- **Response path:** combinational from `mem_rvalid_i` to the FIFO head to the port rvalid, in the same cycle. A response for a grant in cycle N can appear at N+1 at the earliest.
- **Registered outputs:** `outstanding_o` and `spurious_rsp_o`.
- **Reset (async assert, sync-released):**
  - FIFO empty, count 0, `lock` = 0, `last_grant` = data.
  - `spurious_rsp_o` = 0 and `outstanding_o` = 0.
  - With inputs idle, every output is 0.
- **Reset mid-transaction:** all in-flight IDs are discarded. Any later `mem_rvalid_i` for those transactions is spurious and dropped.

## Test plan
1. **Single fetch:** instr_req with addr 0x80 and `mem_gnt_i` = 1, then rvalid with rdata 0x00000013 at the next cycle → `instr_gnt_o` = 1 in the grant cycle. `instr_rvalid_o` = 1 with rdata 0x13. `data_rvalid_o` stays 0 and `outstanding_o` goes 1 → 0.
2. **Round-robin:** both reqs held high with gnt always 1 → grants alternate instr, data, instr, data starting from reset. Responses return in grant order to the matching ports.
3. **Lock:** instr_req with gnt = 0 for 3 cycles, data_req raised in cycle 1 → `mem_addr_o` stays the instr address and `data_gnt_o` = 0 throughout. The instr grant fires when gnt rises, and data is granted the cycle after.
4. **Full:** `MaxOutstanding` = 2; two grants with no responses → `outstanding_o` = 2 and `mem_req_o` = 0 despite data_req = 1. One rvalid in a cycle → a grant is possible in the following cycle.
5. **Spurious error:** nothing outstanding, `mem_rvalid_i` = 1 and `mem_err_i` = 1 for one cycle → both port rvalid and err outputs stay 0. `spurious_rsp_o` = 1 the next cycle and `outstanding_o` stays 0.
6. **Reset mid-flight:** one data load granted, `rst_i` pulsed before its rvalid → all outputs 0 and count 0. The late rvalid is dropped and `spurious_rsp_o` pulses.
